// File: rtl/qua3_ram_reader.sv
// qua3_ram_reader
//   Scans a run of words from a 16x8 synchronous-read RAM, decodes each
//   excess-3 byte back to a binary digit and presents it on a valid/ready
//   stream together with the source address and an error flag.
//   Each word takes three states: REQ (issue the read), CAP (latch and decode
//   the registered RAM data) and OUT (hold the result until the handshake).
//   Optional feature: define QUA3_RD_ERRCNT_EN to add the err_cnt output, a
//   count of accepted words that carried an illegal code.
module qua3_ram_reader #(
    parameter int         ADDR_W  = 4,
    parameter logic [3:0] ERR_VAL = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cs,
    output logic              ram_we,
    input  logic [7:0]        ram_dout,
    output logic [3:0]        dout,
    output logic              dout_err,
    output logic [ADDR_W-1:0] dout_addr,
    output logic              dout_valid,
    input  logic              dout_ready
`ifdef QUA3_RD_ERRCNT_EN
    ,
    output logic [ADDR_W:0]   err_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_CAP  = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [3:0]        dout_q, dout_d;
    logic              dout_err_q, dout_err_d;
    logic [ADDR_W-1:0] dout_addr_q, dout_addr_d;
    logic [3:0]        dec_val;
    logic              dec_err;
    logic              start_acc;
    logic              word_acc;
`ifdef QUA3_RD_ERRCNT_EN
    logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
`endif

    assign start_acc = (state_q == ST_IDLE) && start;
    assign word_acc  = (state_q == ST_OUT) && dout_ready;

    // State register plus all datapath flops; rst overrides every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            dout_q      <= '0;
            dout_err_q  <= 1'b0;
            dout_addr_q <= '0;
`ifdef QUA3_RD_ERRCNT_EN
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            dout_q      <= dout_d;
            dout_err_q  <= dout_err_d;
            dout_addr_q <= dout_addr_d;
`ifdef QUA3_RD_ERRCNT_EN
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    // Next-state logic: one read per word, stall in OUT until accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_REQ;
            ST_REQ:  state_d = ST_CAP;
            ST_CAP:  state_d = ST_OUT;
            ST_OUT: begin
                if (dout_ready) begin
                    state_d = (remaining_q == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state; the port is read-only.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        ram_cs     = (state_q == ST_REQ);
        ram_we     = 1'b0;
        ram_addr   = ptr_q;
        dout_valid = (state_q == ST_OUT);
        dout       = dout_q;
        dout_err   = dout_err_q;
        dout_addr  = dout_addr_q;
    end

    // Excess-3 decode; an unknown bit fails the comparison and lands on the error path.
    always_comb begin
        dec_val = ERR_VAL;
        dec_err = 1'b1;
        if ((ram_dout[7:4] == 4'd0) && (ram_dout[3:0] >= 4'd3) && (ram_dout[3:0] <= 4'd12)) begin
            dec_val = ram_dout[3:0] - 4'd3;
            dec_err = 1'b0;
        end
    end

    // Datapath updates: capture on start, latch decode in CAP, advance on accept.
    always_comb begin
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        dout_d      = dout_q;
        dout_err_d  = dout_err_q;
        dout_addr_d = dout_addr_q;
        if (start_acc) begin
            ptr_d       = base_addr;
            remaining_d = len;
        end
        if (state_q == ST_CAP) begin
            dout_d      = dec_val;
            dout_err_d  = dec_err;
            dout_addr_d = ptr_q;
        end
        if (word_acc && (remaining_q != '0)) begin
            ptr_d       = ptr_q + ADDR_W'(1);
            remaining_d = remaining_q - ADDR_W'(1);
        end
    end

`ifdef QUA3_RD_ERRCNT_EN
    // Error counter: cleared per scan, bumped for each accepted illegal word.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (start_acc) begin
            err_cnt_d = '0;
        end else if (word_acc && dout_err_q) begin
            err_cnt_d = err_cnt_q + (ADDR_W+1)'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
